// File: rtl/ps2_host_cmd.sv
// PS/2 host command transmitter: inhibits the clock, sends a command byte (and optional
// argument byte), then waits for the device 0xFA acknowledge. Option macro: PS2_TX_RESEND_EN.
module ps2_host_cmd #(
    parameter int unsigned CLK_INHIBIT = 10000,
    parameter int unsigned FRAME_TMO   = 200000,
    parameter int unsigned ACK_TMO     = 2000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2ck,
    input  logic       ps2d,
    output logic       ps2ck_oe,
    output logic       ps2d_oe,
    input  logic       req,
    input  logic [7:0] cmd,
    input  logic [7:0] arg,
    input  logic       has_arg,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [7:0] {
        StIdle    = 8'b0000_0001,
        StInhibit = 8'b0000_0010,
        StStart   = 8'b0000_0100,
        StBits    = 8'b0000_1000,
        StLack    = 8'b0001_0000,
        StWaitAck = 8'b0010_0000,
        StDone    = 8'b0100_0000,
        StErr     = 8'b1000_0000
    } state_e;

    localparam logic [7:0] RespAck    = 8'hFA;
    localparam logic [7:0] RespResend = 8'hFE;

    state_e      state_q, state_d;
    logic        ck_r1_q, ck_r2_q;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  arg_q, arg_d;
    logic        has_arg_q, has_arg_d;
    logic        cur_arg_q, cur_arg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_oe_q, tx_oe_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        fall;
    logic [7:0]  cur_byte;

`ifdef PS2_TX_RESEND_EN
    localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RetryW-1:0] retry_q, retry_d;
`endif

    assign fall     = ~ck_r1_q & ck_r2_q;
    assign cur_byte = cur_arg_q ? arg_q : cmd_q;
    assign err_code = err_code_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ck_r1_q    <= 1'b1;
            ck_r2_q    <= 1'b1;
            cmd_q      <= 8'h00;
            arg_q      <= 8'h00;
            has_arg_q  <= 1'b0;
            cur_arg_q  <= 1'b0;
            bit_cnt_q  <= 4'd0;
            tx_oe_q    <= 1'b0;
            timer_q    <= 32'd0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            ck_r1_q    <= ps2ck;
            ck_r2_q    <= ck_r1_q;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            has_arg_q  <= has_arg_d;
            cur_arg_q  <= cur_arg_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_oe_q    <= tx_oe_d;
            timer_q    <= timer_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef PS2_TX_RESEND_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        has_arg_d  = has_arg_q;
        cur_arg_d  = cur_arg_q;
        bit_cnt_d  = bit_cnt_q;
        tx_oe_d    = tx_oe_q;
        timer_d    = timer_q;
        err_code_d = err_code_q;
`ifdef PS2_TX_RESEND_EN
        retry_d    = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    cmd_d      = cmd;
                    arg_d      = arg;
                    has_arg_d  = has_arg;
                    cur_arg_d  = 1'b0;
                    err_code_d = 2'd0;
                    timer_d    = 32'd0;
`ifdef PS2_TX_RESEND_EN
                    retry_d    = '0;
`endif
                    state_d    = StInhibit;
                end
            end
            StInhibit: begin
                if (timer_q >= CLK_INHIBIT - 1) begin
                    timer_d = 32'd0;
                    state_d = StStart;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StStart: begin
                // Keep the start bit on the data line once the clock is released.
                tx_oe_d   = 1'b1;
                bit_cnt_d = 4'd0;
                timer_d   = 32'd0;
                state_d   = StBits;
            end
            StBits: begin
                if (timer_q >= FRAME_TMO - 1) begin
                    tx_oe_d    = 1'b0;
                    err_code_d = 2'd2;
                    state_d    = StErr;
                end else begin
                    timer_d = timer_q + 32'd1;
                    if (fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            tx_oe_d = ~cur_byte[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            // Odd parity bit is ~^byte; the line driver is its complement.
                            tx_oe_d = ^cur_byte;
                        end else begin
                            tx_oe_d = 1'b0;
                            state_d = StLack;
                        end
                    end
                end
            end
            StLack: begin
                if (timer_q >= FRAME_TMO - 1) begin
                    err_code_d = 2'd2;
                    state_d    = StErr;
                end else begin
                    timer_d = timer_q + 32'd1;
                    if (fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        timer_d   = 32'd0;
                        if (!ps2d) begin
                            state_d = StWaitAck;
                        end else begin
                            err_code_d = 2'd1;
                            state_d    = StErr;
                        end
                    end
                end
            end
            StWaitAck: begin
                if (rx_valid) begin
                    timer_d = 32'd0;
                    if (rx_byte == RespAck) begin
                        if (!cur_arg_q && has_arg_q) begin
                            cur_arg_d = 1'b1;
`ifdef PS2_TX_RESEND_EN
                            retry_d   = '0;
`endif
                            state_d   = StInhibit;
                        end else begin
                            state_d = StDone;
                        end
                    end else if (rx_byte == RespResend) begin
`ifdef PS2_TX_RESEND_EN
                        if (retry_q < RetryW'(MAX_RETRY)) begin
                            retry_d = retry_q + 1'b1;
                            state_d = StInhibit;
                        end else begin
                            err_code_d = 2'd3;
                            state_d    = StErr;
                        end
`else
                        err_code_d = 2'd3;
                        state_d    = StErr;
`endif
                    end else begin
                        err_code_d = 2'd3;
                        state_d    = StErr;
                    end
                end else if (timer_q >= ACK_TMO - 1) begin
                    err_code_d = 2'd2;
                    state_d    = StErr;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StDone, StErr: begin
                timer_d   = 32'd0;
                bit_cnt_d = 4'd0;
                tx_oe_d   = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ps2ck_oe = (state_q == StInhibit) || (state_q == StStart);
        ps2d_oe  = (state_q == StStart) || ((state_q == StBits) && tx_oe_q);
        busy     = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
        done     = (state_q == StDone);
        err      = (state_q == StErr);
    end

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Self-checking bench for ps2_host_cmd: a PS/2 device model clocks frames, returns line-ack and
// response bytes; sent bytes are checked against a queue of expected bytes per transaction.
module tb_ps2_host_cmd;

    localparam int unsigned ClkInhibit = 20;
    localparam int unsigned FrameTmo   = 2000;
    localparam int unsigned AckTmo     = 3000;
    localparam int unsigned MaxRetry   = 3;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  arg;
        logic        has_arg;
        logic        lack;
        logic        no_resp;
        logic        spur;
        int          n_fe;
        logic [7:0]  resp;
        int          exp_frames;
        logic [31:0] exp_bytes;
        logic        exp_done;
        logic [1:0]  exp_code;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dev_ck = 1'b1;
    logic       dev_d = 1'b1;
    logic       req = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [7:0] arg = 8'h00;
    logic       has_arg = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ps2ck_oe, ps2d_oe, busy, done, err;
    logic [1:0] err_code;
    wire        ps2ck_line = dev_ck & ~ps2ck_oe;
    wire        ps2d_line  = dev_d & ~ps2d_oe;

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    ps2_host_cmd #(
        .CLK_INHIBIT(ClkInhibit),
        .FRAME_TMO  (FrameTmo),
        .ACK_TMO    (AckTmo),
        .MAX_RETRY  (MaxRetry)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2ck   (ps2ck_line),
        .ps2d    (ps2d_line),
        .ps2ck_oe(ps2ck_oe),
        .ps2d_oe (ps2d_oe),
        .req     (req),
        .cmd     (cmd),
        .arg     (arg),
        .has_arg (has_arg),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_code(err_code)
    );

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [7:0] c, input logic [7:0] a, input logic h,
                                input logic l, input logic nr, input logic sp, input int nfe,
                                input logic [7:0] rsp, input int nfr, input logic [31:0] bytes,
                                input logic dn, input logic [1:0] code);
        vec_t v;
        v.cmd = c; v.arg = a; v.has_arg = h; v.lack = l; v.no_resp = nr; v.spur = sp;
        v.n_fe = nfe; v.resp = rsp; v.exp_frames = nfr; v.exp_bytes = bytes;
        v.exp_done = dn; v.exp_code = code;
        return v;
    endfunction

    // Device side of one frame: measures inhibit/start, clocks 11 falls, optionally line-acks.
    task automatic dev_frame(input string tag, input logic ack, input logic chk_inh);
        int cnt;
        logic [10:1] bits;
        logic [7:0] eb;
        cnt = 0;
        while (ps2ck_oe && !ps2d_oe && cnt < 10 * ClkInhibit) begin
            cnt++;
            @(negedge clk);
        end
        if (chk_inh) check({tag, "_inhibit_len"}, cnt, ClkInhibit);
        cnt = 0;
        while (ps2ck_oe && ps2d_oe && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_start_len"}, cnt, 1);
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) dev_d = 1'b0;
            dev_ck = 1'b0;
            repeat (8) @(negedge clk);
            if (i <= 10) bits[i] = ps2d_line;
            dev_ck = 1'b1;
            repeat (8) @(negedge clk);
            dev_d = 1'b1;
        end
        check({tag, "_frame_expected"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            check({tag, "_data"}, bits[8:1], eb);
            check({tag, "_parity"}, bits[9], ~^eb);
            check({tag, "_stop"}, bits[10], 1'b1);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int d0, e0, frames, k;
        logic go;
        string tag;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int f = 0; f < v.exp_frames; f++) exp_q.push_back(v.exp_bytes[8*f +: 8]);
        @(negedge clk);
        req = 1'b1; cmd = v.cmd; arg = v.arg; has_arg = v.has_arg;
        @(negedge clk);
        req = 1'b0;
        check($sformatf("v%0d_busy_after_req", idx), busy, 1'b1);
        if (v.spur) begin
            req = 1'b1; cmd = 8'h55; has_arg = 1'b1; rx_valid = 1'b1; rx_byte = 8'hFE;
            @(negedge clk);
            req = 1'b0; rx_valid = 1'b0;
        end
        frames = 0;
        go = 1'b1;
        while (go) begin
            k = 0;
            while (!ps2ck_oe && done_cnt == d0 && err_cnt == e0 && k < int'(AckTmo) + 500) begin
                k++;
                @(negedge clk);
            end
            if (ps2ck_oe && frames < 6) begin
                tag = $sformatf("v%0d_f%0d", idx, frames);
                dev_frame(tag, v.lack, !(v.spur && frames == 0));
                if (v.lack && !v.no_resp) begin
                    repeat (20) @(negedge clk);
                    rx_valid = 1'b1;
                    rx_byte = (frames < v.n_fe) ? 8'hFE : v.resp;
                    @(negedge clk);
                    rx_valid = 1'b0;
                end
                frames++;
            end else begin
                go = 1'b0;
            end
        end
        repeat (5) @(negedge clk);
        check($sformatf("v%0d_frames", idx), frames, v.exp_frames);
        check($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 32'(v.exp_done));
        check($sformatf("v%0d_err_pulses", idx), err_cnt - e0, 32'(!v.exp_done));
        check($sformatf("v%0d_err_code", idx), err_code, v.exp_code);
        check($sformatf("v%0d_busy_end", idx), busy, 1'b0);
        check($sformatf("v%0d_lines_released", idx), {ps2ck_oe, ps2d_oe}, 2'b00);
        exp_q.delete();
    endtask

    initial begin
        int d0, e0, n;
        vecs[0] = mk(8'hED, 8'h00, 0, 1, 0, 0, 0, 8'hFA, 1, 32'h0000_00ED, 1, 0);
        vecs[1] = mk(8'hED, 8'h07, 1, 1, 0, 0, 0, 8'hFA, 2, 32'h0000_07ED, 1, 0);
        vecs[2] = mk(8'hF3, 8'h00, 0, 0, 0, 0, 0, 8'hFA, 1, 32'h0000_00F3, 0, 1);
        vecs[3] = mk(8'hF4, 8'h00, 0, 1, 0, 1, 0, 8'hFA, 1, 32'h0000_00F4, 1, 0);
        vecs[4] = mk(8'h55, 8'h00, 0, 1, 0, 0, 0, 8'hAA, 1, 32'h0000_0055, 0, 3);
        vecs[5] = mk(8'hEE, 8'h00, 0, 1, 1, 0, 0, 8'hFA, 1, 32'h0000_00EE, 0, 2);
`ifdef PS2_TX_RESEND_EN
        vecs[6] = mk(8'hFF, 8'h00, 0, 1, 0, 0, 3, 8'hFA, 4, 32'hFFFF_FFFF, 1, 0);
        vecs[7] = mk(8'hF2, 8'h00, 0, 1, 0, 0, 4, 8'hFA, 4, 32'hF2F2_F2F2, 0, 3);
`else
        vecs[6] = mk(8'hFF, 8'h00, 0, 1, 0, 0, 3, 8'hFA, 1, 32'h0000_00FF, 0, 3);
        vecs[7] = mk(8'hF2, 8'h00, 0, 1, 0, 0, 4, 8'hFA, 1, 32'h0000_00F2, 0, 3);
`endif

        repeat (3) @(negedge clk);
        check("rst_ps2ck_oe", ps2ck_oe, 1'b0);
        check("rst_ps2d_oe", ps2d_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // No device clocks after START: frame timer must expire.
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1; cmd = 8'hF4; has_arg = 1'b0;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (ps2ck_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (!err && n < int'(FrameTmo) + 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_err_seen", err, 1'b1);
        check("tmo_window", 32'(n >= int'(FrameTmo) - 1 && n <= int'(FrameTmo) + 1), 1);
        check("tmo_err_code", err_code, 2'd2);
        check("tmo_lines_released", {ps2ck_oe, ps2d_oe}, 2'b00);
        @(negedge clk);
        check("tmo_err_one_cycle", err, 1'b0);
        check("tmo_no_done", done_cnt - d0, 0);

        // Reset while bit 4 of 0x00 is on the line.
        @(negedge clk);
        req = 1'b1; cmd = 8'h00;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (ps2ck_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_ck = 1'b0;
            repeat (8) @(negedge clk);
            if (i < 4) begin
                dev_ck = 1'b1;
                repeat (8) @(negedge clk);
            end
        end
        check("rstmid_bit4_driven", ps2d_oe, 1'b1);
        check("rstmid_busy_before", busy, 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_ps2ck_oe", ps2ck_oe, 1'b0);
        check("rstmid_ps2d_oe", ps2d_oe, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        dev_ck = 1'b1;
        repeat (300) @(negedge clk);
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_no_err", err_cnt - e0, 0);
        check("rstmid_err_code", err_code, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
